// File: rtl/radiant_scaler_bank.sv
// Per-channel trigger-rate scaler bank: counts single-cycle flags over a gate interval
// (internal period or PPS), double-buffers the result and serves it on a register-read port.
module radiant_scaler_bank #(
  parameter int NUM_CH     = 24,
  parameter int CNT_WIDTH  = 16,
  parameter int GATE_WIDTH = 28
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_CH-1:0]     scal_i,
  input  logic                  pps_i,
  input  logic                  gate_sel_i,
  input  logic [GATE_WIDTH-1:0] gate_period_i,
  input  logic                  rd_stb_i,
  input  logic [4:0]            rd_addr_i,
  output logic                  rd_ack_o,
  output logic [31:0]           rd_dat_o,
  output logic                  update_o
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [GATE_WIDTH-1:0] GATE_ONE    = GATE_WIDTH'(1);
  localparam logic [4:0]            STATUS_ADDR = 5'(NUM_CH);

  logic [GATE_WIDTH-1:0]             gate_cnt_q, gate_cnt_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  run_q, run_d;
  logic [NUM_CH-1:0]                 run_sat_q, run_sat_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  held_q, held_d;
  logic [NUM_CH-1:0]                 held_sat_q, held_sat_d;
  logic [15:0]                       seq_q, seq_d;
  logic                              gate_mode_q, gate_mode_d;
  logic                              update_q;
  logic                              rd_ack_q;
  logic [31:0]                       rd_dat_q, rd_dat_d;
  logic                              gate_end;

  // The >= compare lets a gate close immediately if the period shrinks below the
  // cycles already elapsed.
  always_comb begin
    gate_end = 1'b0;
    if (gate_sel_i) begin
      gate_end = pps_i;
    end else if (gate_period_i != '0) begin
      gate_end = (gate_cnt_q >= (gate_period_i - GATE_ONE));
    end
  end

  always_comb begin
    gate_cnt_d = gate_cnt_q + GATE_ONE;
    if (gate_sel_i || (gate_period_i == '0) || gate_end) begin
      gate_cnt_d = '0;
    end
  end

  // A flag coincident with gate_end is counted in the new gate, not the closing one.
  always_comb begin
    run_d       = run_q;
    run_sat_d   = run_sat_q;
    held_d      = held_q;
    held_sat_d  = held_sat_q;
    seq_d       = seq_q;
    gate_mode_d = gate_mode_q;
    if (gate_end) begin
      held_d      = run_q;
      held_sat_d  = run_sat_q;
      seq_d       = seq_q + 16'd1;
      gate_mode_d = gate_sel_i;
      run_sat_d   = '0;
      for (int n = 0; n < NUM_CH; n++) begin
        run_d[n] = scal_i[n] ? CNT_ONE : '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (scal_i[n]) begin
          if (run_q[n] == CNT_MAX) begin
            run_sat_d[n] = 1'b1;
          end else begin
            run_d[n] = run_q[n] + CNT_ONE;
          end
        end
      end
    end
  end

  // Read port: rd_stb_i is a one-cycle request with no backpressure; rd_ack_o follows
  // exactly one cycle later with rd_dat_o valid, and rd_dat_o is zero whenever ack is low.
  always_comb begin
    rd_dat_d = 32'h0;
    if (rd_stb_i) begin
      if (rd_addr_i < STATUS_ADDR) begin
        rd_dat_d     = 32'(held_q[rd_addr_i]);
        rd_dat_d[31] = held_sat_q[rd_addr_i];
      end else if (rd_addr_i == STATUS_ADDR) begin
        rd_dat_d = {gate_mode_q, 15'b0, seq_q};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_cnt_q  <= '0;
      run_q       <= '0;
      run_sat_q   <= '0;
      held_q      <= '0;
      held_sat_q  <= '0;
      seq_q       <= '0;
      gate_mode_q <= 1'b0;
      update_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_dat_q    <= 32'h0;
    end else begin
      gate_cnt_q  <= gate_cnt_d;
      run_q       <= run_d;
      run_sat_q   <= run_sat_d;
      held_q      <= held_d;
      held_sat_q  <= held_sat_d;
      seq_q       <= seq_d;
      gate_mode_q <= gate_mode_d;
      update_q    <= gate_end;
      rd_ack_q    <= rd_stb_i;
      rd_dat_q    <= rd_dat_d;
    end
  end

  assign update_o = update_q;
  assign rd_ack_o = rd_ack_q;
  assign rd_dat_o = rd_dat_q;

endmodule

// File: tb/tb_radiant_scaler_bank.sv
// Bench for radiant_scaler_bank: directed steps plus randomized traffic, each cycle
// compared against an integer-count reference model of the scaler bank.
module tb_radiant_scaler_bank;

  localparam int NUM_CH     = 24;
  localparam int CNT_WIDTH  = 16;
  localparam int GATE_WIDTH = 28;
  localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NUM_CH-1:0]     scal_i = '0;
  logic                  pps_i = 1'b0;
  logic                  gate_sel_i = 1'b0;
  logic [GATE_WIDTH-1:0] gate_period_i = '0;
  logic                  rd_stb_i = 1'b0;
  logic [4:0]            rd_addr_i = '0;
  logic                  rd_ack_o;
  logic [31:0]           rd_dat_o;
  logic                  update_o;

  int checks = 0;
  int errors = 0;

  radiant_scaler_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .GATE_WIDTH(GATE_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .scal_i(scal_i), .pps_i(pps_i),
    .gate_sel_i(gate_sel_i), .gate_period_i(gate_period_i),
    .rd_stb_i(rd_stb_i), .rd_addr_i(rd_addr_i),
    .rd_ack_o(rd_ack_o), .rd_dat_o(rd_dat_o), .update_o(update_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: unbounded integer counts, clipped only when a gate closes.
  int unsigned m_cnt  [NUM_CH];
  int unsigned m_held [NUM_CH];
  bit          m_hsat [NUM_CH];
  int unsigned m_seq;
  bit          m_mode;
  int unsigned m_age;
  bit          m_ge;
  bit          exp_upd;
  bit          exp_ack;
  logic [31:0] exp_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_cnt[n] = 0; m_held[n] = 0; m_hsat[n] = 0;
    end
    m_seq = 0; m_mode = 0; m_age = 0; m_ge = 0;
    exp_upd = 0; exp_ack = 0; exp_dat = 32'h0;
  endtask

  function automatic logic [31:0] model_word(input int a);
    if (a < NUM_CH) return (m_hsat[a] ? 32'h8000_0000 : 32'h0) | 32'(m_held[a]);
    if (a == NUM_CH) return (m_mode ? 32'h8000_0000 : 32'h0) | 32'(m_seq);
    return 32'h0;
  endfunction

  // One clock: model consumes current inputs, then DUT outputs are checked 1 ns after the edge.
  task automatic step();
    if (rst_i) begin
      model_reset();
    end else begin
      exp_ack = rd_stb_i;
      exp_dat = rd_stb_i ? model_word(int'(rd_addr_i)) : 32'h0;
      if (gate_sel_i) m_ge = pps_i;
      else m_ge = (gate_period_i != 0) && (m_age + 1 >= int'(gate_period_i));
      for (int n = 0; n < NUM_CH; n++) begin
        if (m_ge) begin
          m_held[n] = (m_cnt[n] > CNT_MAX) ? CNT_MAX : m_cnt[n];
          m_hsat[n] = (m_cnt[n] > CNT_MAX);
          m_cnt[n]  = scal_i[n];
        end else begin
          m_cnt[n] += scal_i[n];
        end
      end
      if (m_ge) begin
        m_seq  = (m_seq + 1) % 65536;
        m_mode = gate_sel_i;
      end
      m_age   = (gate_sel_i || gate_period_i == 0 || m_ge) ? 0 : m_age + 1;
      exp_upd = m_ge;
    end
    @(posedge clk_i);
    #1;
    chk("update_o", 32'(update_o), 32'(exp_upd));
    chk("rd_ack_o", 32'(rd_ack_o), 32'(exp_ack));
    chk("rd_dat_o", rd_dat_o, exp_dat);
  endtask

  task automatic rd(input int addr, output logic [31:0] d);
    rd_stb_i  = 1'b1;
    rd_addr_i = 5'(addr);
    step();
    d = rd_dat_o;
    rd_stb_i = 1'b0;
  endtask

  task automatic rand_scal();
    logic [31:0] r;
    r = $urandom & $urandom & $urandom;
    scal_i = r[NUM_CH-1:0];
  endtask

  task automatic sync_gate();
    int found;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (m_ge) found = 1;
    end
    chk("gate_sync", 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] d, d_old, d_new, d_hi;
    int upd_at, upd_cnt;
    int unsigned s0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_update", 32'(update_o), 32'd0);
    chk("reset_ack", 32'(rd_ack_o), 32'd0);
    chk("reset_dat", rd_dat_o, 32'h0);
    rst_i = 1'b0;

    // Count, then reset asynchronously mid-gate while a read ack is outstanding
    gate_period_i = 28'd100;
    for (int i = 0; i < 30; i++) begin rand_scal(); step(); end
    scal_i = '0;
    rd(NUM_CH, d);
    rst_i = 1'b1;
    #2;
    chk("async_rst_ack", 32'(rd_ack_o), 32'd0);
    chk("async_rst_upd", 32'(update_o), 32'd0);
    chk("async_rst_dat", rd_dat_o, 32'h0);
    step();
    rst_i = 1'b0;
    gate_period_i = '0;
    rd(0, d);
    chk("post_rst_ack", 32'(rd_ack_o), 32'd1);
    chk("post_rst_rd0", d, 32'h0);
    rd(NUM_CH, d);
    chk("post_rst_rd24", d, 32'h0);

    // Internal gate of 100 cycles, 10 pulses on channel 3
    gate_period_i = 28'd100;
    upd_at = 0;
    for (int i = 1; i <= 101; i++) begin
      scal_i = (i >= 5 && i <= 14) ? NUM_CH'(1 << 3) : '0;
      step();
      if (update_o && upd_at == 0) upd_at = i;
    end
    scal_i = '0;
    chk("update_after_100", 32'(upd_at), 32'd100);
    rd(3, d);
    chk("rd3_ten", d, 32'h0000_000A);
    rd(NUM_CH, d);
    chk("rd24_seq1", d, 32'h0000_0001);
    rd(0, d);
    chk("rd0_zero", d, 32'h0);

    // Randomized traffic: period changes (including shrink mid-gate), source switches, reads
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gate_sel_i    = ($urandom_range(0, 3) == 0);
        gate_period_i = GATE_WIDTH'($urandom_range(0, 40));
      end
      if (i % 200 == 100 && !gate_sel_i) gate_period_i = GATE_WIDTH'($urandom_range(1, 10));
      pps_i     = ($urandom_range(0, 60) == 0);
      rd_stb_i  = ($urandom_range(0, 2) == 0);
      rd_addr_i = 5'($urandom_range(0, 31));
      rand_scal();
      step();
    end
    pps_i = 0; rd_stb_i = 0; scal_i = '0; gate_sel_i = 0;

    // Coincident flag and coincident read at gate_end on channel 5
    gate_period_i = 28'd50;
    sync_gate();
    for (int k = 1; k <= 50; k++) begin
      scal_i = (k == 10 || k == 20 || k == 30) ? NUM_CH'(1 << 5) : '0;
      step();
    end
    for (int k = 1; k <= 50; k++) begin
      scal_i   = (k % 10 == 0) ? NUM_CH'(1 << 5) : '0;
      rd_stb_i = (k == 50);
      rd_addr_i = 5'd5;
      step();
      if (k == 50) d_old = rd_dat_o;
    end
    d_new = 32'h0; d_hi = 32'h0;
    for (int k = 1; k <= 50; k++) begin
      scal_i    = (k == 10) ? NUM_CH'(1 << 5) : '0;
      rd_stb_i  = (k <= 2);
      rd_addr_i = (k == 1) ? 5'd5 : 5'd31;
      step();
      if (k == 1) d_new = rd_dat_o;
      if (k == 2) begin
        d_hi = rd_dat_o;
        chk("rd31_ack", 32'(rd_ack_o), 32'd1);
      end
    end
    scal_i = '0; rd_stb_i = 0;
    chk("gate_end_read_old", d_old, 32'h0000_0003);
    chk("next_read_new", d_new, 32'h0000_0004);
    chk("rd31_zero", d_hi, 32'h0);
    rd(5, d);
    chk("coincident_carry", d, 32'h0000_0002);

    // PPS gating: internal period must be ignored
    gate_sel_i = 1; gate_period_i = 28'd50;
    s0 = m_seq;
    for (int p = 0; p < 3; p++) begin
      upd_cnt = 0;
      for (int k = 1; k <= 1000; k++) begin
        pps_i = (k == 1000);
        rand_scal();
        step();
        if (update_o) upd_cnt++;
      end
      pps_i = 0; scal_i = '0;
      chk("pps_one_update", 32'(upd_cnt), 32'd1);
      rd(NUM_CH, d);
      chk("pps_mode", 32'(d[31]), 32'd1);
      chk("pps_seq", 32'(d[15:0]), (s0 + p + 1) % 65536);
    end
    pps_i = 1;
    for (int k = 0; k < 300; k++) begin rand_scal(); step(); end
    pps_i = 0; scal_i = '0;
    rd(NUM_CH, d);
    chk("pps_fast_seq", 32'(d[15:0]), (s0 + 303) % 65536);

    // Saturation: channel 0 high well past all-ones within one PPS gate
    scal_i = NUM_CH'(1);
    for (int k = 0; k < 65600; k++) step();
    scal_i = '0;
    pps_i = 1; step(); pps_i = 0;
    rd(0, d);
    chk("sat_rd0", d, 32'h8000_FFFF);
    pps_i = 1; step(); pps_i = 0;
    rd(0, d);
    chk("sat_cleared", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
